dcache_wb_arbiter: RTL and testbench
====================================

DCACHE_WB_ARBITER -- requirements
Module: dcache_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, byte-address width of all address ports.
REQ-002 SHALL have parameter LINE_WIDTH, 128, cache-line width in bits; a legal value is a multiple of 32 and at least 64.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fifo_wen_i, input, 1, write-buffer head valid and not yet accepted.
REQ-006 SHALL have port fifo_awaddr_i, input, ADDR_WIDTH, line address of the write-buffer head.
REQ-007 SHALL have port fifo_wdata_i, input, LINE_WIDTH, line data of the write-buffer head.
REQ-008 SHALL have port fifo_req_accept_o, output, 1, one-cycle pulse when the fifo request is accepted by AXI.
REQ-009 SHALL have port fifo_bvalid_o, output, 1, one-cycle pulse when the write response for the fifo transaction returns.
REQ-010 SHALL have port uc_wreq_i, input, 1, uncached store request, held until uc_done_o.
REQ-011 SHALL have port uc_awaddr_i, input, ADDR_WIDTH, byte address of the uncached store.
REQ-012 SHALL have port uc_wdata_i, input, 32, uncached store word.
REQ-013 SHALL have port uc_wstrb_i, input, 4, uncached store byte enables.
REQ-014 SHALL have port uc_done_o, output, 1, one-cycle pulse when the uncached write response returns.
REQ-015 SHALL have port axi_wreq_o, output, 1, write request to the AXI bridge.
REQ-016 SHALL have port axi_awaddr_o, output, ADDR_WIDTH, AXI write address.
REQ-017 SHALL have port axi_wdata_o, output, LINE_WIDTH, AXI write data.
REQ-018 SHALL have port axi_wstrb_o, output, LINE_WIDTH/8, AXI byte strobes.
REQ-019 SHALL have port axi_len_o, output, 8, AXI burst length minus one.
REQ-020 SHALL have port axi_wready_i, input, 1, bridge accepts the current request this cycle.
REQ-021 SHALL have port axi_bvalid_i, input, 1, bridge write response.
REQ-022 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-023 SHALL implement the three-state FSM IDLE -> REQ -> RESP -> IDLE.
REQ-024 SHALL grant in IDLE when either request is high, move to REQ in the next cycle, and latch owner, address, data, strobe and len in the grant cycle.
REQ-025 SHALL grant the single requester if only one requests; if both request, it SHALL grant the one not granted last (round-robin via last_owner, reset value fifo, so uc wins the first tie).
REQ-026 SHALL, for a fifo grant, drive awaddr = fifo_awaddr_i with the low log2(LINE_WIDTH/8) bits cleared, wdata = fifo_wdata_i, all strobes = 1, and len = LINE_WIDTH/32-1.
REQ-027 SHALL, for a uc grant, drive awaddr = uc_awaddr_i, place the 32-bit word in lane uc_awaddr_i[log2(LINE_WIDTH/8)-1:2], set only that lane's 4 strobes from uc_wstrb_i (all others 0), and drive len = 0.
REQ-028 SHALL, in REQ, hold axi_wreq_o = 1 with stable latched payload until axi_wready_i; on axi_wready_i it SHALL go to RESP and pulse fifo_req_accept_o in the same cycle if the owner is fifo.
REQ-029 SHALL keep axi_wreq_o at 0 in IDLE and RESP.
REQ-030 SHALL, in RESP, on axi_bvalid_i pulse fifo_bvalid_o or uc_done_o (by owner) for exactly one cycle, update last_owner and return to IDLE.
REQ-031 SHALL take the next grant no earlier than the cycle after the return to IDLE; back-to-back transactions SHALL therefore cost at least 3 cycles each.
REQ-032 SHALL ignore axi_bvalid_i outside RESP and axi_wready_i outside REQ.
REQ-033 SHALL ignore requester inputs that change after the grant; only the latched values drive AXI.
REQ-034 SHALL have no combinational path from any *_i to axi_wreq_o, axi_awaddr_o, axi_wdata_o, axi_wstrb_o or axi_len_o.

Reset
REQ-035 SHALL on rst low force state = IDLE, last_owner = fifo, all pulse outputs and axi_wreq_o = 0, busy_o = 0, and payload registers = 0.
REQ-036 SHALL, on reset asserted mid-transaction, drop the transaction with no done/bvalid pulse; after release it SHALL re-arbitrate only from live requests.

Verification
REQ-037 SHALL be checked with: fifo-only, addr 0x1000_0014, wready on 2nd REQ cycle, bvalid 3 cycles later -> awaddr 0x1000_0010, strb all 1, len 3, one accept pulse, one fifo_bvalid pulse, IDLE.
REQ-038 SHALL be checked with: uc-only, addr 0x1FE0_0008, data 0xDEADBEEF, wstrb 0x3 -> wdata lane 2 = 0xDEADBEEF, wstrb = 0x0300, len 0, uc_done single pulse.
REQ-039 SHALL be checked with: both requesting continuously from reset -> grant order uc, fifo, uc, fifo.
REQ-040 SHALL be checked with: bvalid pulsed during REQ before wready -> no done pulse, FSM stays REQ, the later bvalid in RESP completes.
REQ-041 SHALL be checked with: rst low during RESP -> all outputs 0 the same cycle, no done pulse, and a fresh grant after release.
REQ-042 SHALL be checked with: uc_wdata_i changed the cycle after grant -> axi_wdata_o keeps the originally granted value.

Source files
------------

// File: rtl/dcache_wb_arbiter_if.sv
// Signal bundle between the write-buffer/uncached-store requesters, the arbiter and the AXI bridge.
// The master modport is the arbiter side; the slave modport is the environment side.
interface dcache_wb_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                    fifo_wen_i;
    logic [ADDR_WIDTH-1:0]   fifo_awaddr_i;
    logic [LINE_WIDTH-1:0]   fifo_wdata_i;
    logic                    fifo_req_accept_o;
    logic                    fifo_bvalid_o;

    logic                    uc_wreq_i;
    logic [ADDR_WIDTH-1:0]   uc_awaddr_i;
    logic [31:0]             uc_wdata_i;
    logic [3:0]              uc_wstrb_i;
    logic                    uc_done_o;

    logic                    axi_wreq_o;
    logic [ADDR_WIDTH-1:0]   axi_awaddr_o;
    logic [LINE_WIDTH-1:0]   axi_wdata_o;
    logic [LINE_WIDTH/8-1:0] axi_wstrb_o;
    logic [7:0]              axi_len_o;
    logic                    axi_wready_i;
    logic                    axi_bvalid_i;

    logic                    busy_o;

    modport master (
        input  fifo_wen_i, fifo_awaddr_i, fifo_wdata_i,
        output fifo_req_accept_o, fifo_bvalid_o,
        input  uc_wreq_i, uc_awaddr_i, uc_wdata_i, uc_wstrb_i,
        output uc_done_o,
        output axi_wreq_o, axi_awaddr_o, axi_wdata_o, axi_wstrb_o, axi_len_o,
        input  axi_wready_i, axi_bvalid_i,
        output busy_o
    );

    modport slave (
        output fifo_wen_i, fifo_awaddr_i, fifo_wdata_i,
        input  fifo_req_accept_o, fifo_bvalid_o,
        output uc_wreq_i, uc_awaddr_i, uc_wdata_i, uc_wstrb_i,
        input  uc_done_o,
        input  axi_wreq_o, axi_awaddr_o, axi_wdata_o, axi_wstrb_o, axi_len_o,
        output axi_wready_i, axi_bvalid_i,
        input  busy_o
    );
endinterface

// File: rtl/dcache_wb_arbiter.sv
// Round-robin arbiter between the dcache write buffer (full lines) and uncached stores (one word),
// issuing one AXI write at a time through an IDLE -> REQ -> RESP handshake.
module dcache_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
) (
    input logic                 clk,
    input logic                 rst,
    dcache_wb_arbiter_if.master bus
);
    localparam int unsigned STRB_WIDTH = LINE_WIDTH / 8;
    localparam int unsigned OFF        = $clog2(STRB_WIDTH);
    localparam int unsigned LANE_BITS  = OFF - 2;
    localparam logic [7:0]  LINE_LEN   = 8'(LINE_WIDTH / 32 - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;
    typedef enum logic {OwnFifo, OwnUc} owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e last_owner_q, last_owner_d;

    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [7:0]            len_q, len_d;

    logic                  grant_uc;
    logic                  req_accept;
    logic                  fifo_bvalid;
    logic                  uc_done;
    logic [LANE_BITS-1:0]  uc_lane;
    logic [LINE_WIDTH-1:0] uc_line_data;
    logic [STRB_WIDTH-1:0] uc_line_strb;

    // Place the uncached word and its byte enables into the lane selected by the address.
    assign uc_lane      = bus.uc_awaddr_i[OFF-1:2];
    assign uc_line_data = LINE_WIDTH'(bus.uc_wdata_i) << {uc_lane, 5'b0};
    assign uc_line_strb = STRB_WIDTH'(bus.uc_wstrb_i) << {uc_lane, 2'b0};

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        len_d        = len_q;
        grant_uc     = 1'b0;
        req_accept   = 1'b0;
        fifo_bvalid  = 1'b0;
        uc_done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.fifo_wen_i || bus.uc_wreq_i) begin
                    // On a tie, hand the grant to whoever did not complete last.
                    grant_uc = bus.uc_wreq_i && (!bus.fifo_wen_i || last_owner_q == OwnFifo);
                    state_d  = StReq;
                    if (grant_uc) begin
                        owner_d  = OwnUc;
                        awaddr_d = bus.uc_awaddr_i;
                        wdata_d  = uc_line_data;
                        wstrb_d  = uc_line_strb;
                        len_d    = 8'd0;
                    end else begin
                        owner_d  = OwnFifo;
                        awaddr_d = {bus.fifo_awaddr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        wdata_d  = bus.fifo_wdata_i;
                        wstrb_d  = {STRB_WIDTH{1'b1}};
                        len_d    = LINE_LEN;
                    end
                end
            end
            StReq: begin
                if (bus.axi_wready_i) begin
                    state_d    = StResp;
                    req_accept = (owner_q == OwnFifo);
                end
            end
            StResp: begin
                if (bus.axi_bvalid_i) begin
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                    fifo_bvalid  = (owner_q == OwnFifo);
                    uc_done      = (owner_q == OwnUc);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnFifo;
            last_owner_q <= OwnFifo;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            len_q        <= len_d;
        end
    end

    // AXI request side comes only from registers, so requester inputs never reach it directly.
    assign bus.axi_wreq_o        = (state_q == StReq);
    assign bus.axi_awaddr_o      = awaddr_q;
    assign bus.axi_wdata_o       = wdata_q;
    assign bus.axi_wstrb_o       = wstrb_q;
    assign bus.axi_len_o         = len_q;
    assign bus.busy_o            = (state_q != StIdle);
    assign bus.fifo_req_accept_o = req_accept;
    assign bus.fifo_bvalid_o     = fifo_bvalid;
    assign bus.uc_done_o         = uc_done;
endmodule

// File: tb/tb_dcache_wb_arbiter.sv
// Scoreboard bench for dcache_wb_arbiter: stimulus pushes expected AXI transactions, a negedge
// monitor pops and compares them at each handshake and each completion pulse.
module tb_dcache_wb_arbiter;
    logic clk;
    logic rst;

    dcache_wb_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();

    dcache_wb_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         uc;
        logic [31:0]  awaddr;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
        logic [7:0]   len;
    } txn_t;

    txn_t exp_q[$];
    logic pend_q[$];

    int nvec  = 0;
    int nfail = 0;
    int n_acc = 0;
    int n_fbv = 0;
    int n_ucd = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic uc, input logic [31:0] a, input logic [127:0] d,
                            input logic [15:0] s, input logic [7:0] l);
        txn_t t;
        t.uc = uc; t.awaddr = a; t.wdata = d; t.wstrb = s; t.len = l;
        exp_q.push_back(t);
    endtask

    // Monitor: compares at every AXI handshake and every completion pulse.
    always @(negedge clk) begin
        if (bus.fifo_req_accept_o) n_acc++;
        if (bus.fifo_bvalid_o) n_fbv++;
        if (bus.uc_done_o) n_ucd++;
        if (bus.axi_wreq_o && bus.axi_wready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_handshake", 1'b1, 1'b0);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("awaddr", bus.axi_awaddr_o, e.awaddr);
                chk("wdata", bus.axi_wdata_o, e.wdata);
                chk("wstrb", bus.axi_wstrb_o, e.wstrb);
                chk("len", bus.axi_len_o, e.len);
                chk("req_accept", bus.fifo_req_accept_o, !e.uc);
                pend_q.push_back(e.uc);
            end
        end
        if (bus.fifo_bvalid_o || bus.uc_done_o) begin
            if (pend_q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                logic u;
                u = pend_q.pop_front();
                chk("uc_done_owner", bus.uc_done_o, u);
                chk("fifo_bvalid_owner", bus.fifo_bvalid_o, !u);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in the first REQ cycle; returns in the first IDLE cycle after completion.
    task automatic serve(input int wr_delay, input int b_delay);
        repeat (wr_delay) tick();
        bus.axi_wready_i = 1'b1;
        tick();
        bus.axi_wready_i = 1'b0;
        repeat (b_delay) tick();
        bus.axi_bvalid_i = 1'b1;
        tick();
        bus.axi_bvalid_i = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_busy"}, bus.busy_o, 1'b0);
        chk({nm, "_wreq"}, bus.axi_wreq_o, 1'b0);
    endtask

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D2 = {4{32'hCAFE_F00D}};

    initial begin
        int acc0, fbv0, ucd0;
        rst = 1'b0;
        bus.fifo_wen_i = 1'b0; bus.fifo_awaddr_i = '0; bus.fifo_wdata_i = '0;
        bus.uc_wreq_i = 1'b0; bus.uc_awaddr_i = '0; bus.uc_wdata_i = '0; bus.uc_wstrb_i = '0;
        bus.axi_wready_i = 1'b0; bus.axi_bvalid_i = 1'b0;
        tick(); tick();

        // Reset state
        check_idle("rst");
        chk("rst_awaddr", bus.axi_awaddr_o, 32'h0);
        chk("rst_wdata", bus.axi_wdata_o, 128'h0);
        chk("rst_wstrb", bus.axi_wstrb_o, 16'h0);
        chk("rst_len", bus.axi_len_o, 8'h0);
        chk("rst_pulses", {bus.fifo_req_accept_o, bus.fifo_bvalid_o, bus.uc_done_o}, 3'b000);
        rst = 1'b1;
        tick();

        // Fifo-only line write, wready on 2nd REQ cycle, bvalid in 3rd RESP cycle
        acc0 = n_acc; fbv0 = n_fbv;
        push_exp(1'b0, 32'h1000_0010, D1, 16'hFFFF, 8'd3);
        bus.fifo_wen_i = 1'b1; bus.fifo_awaddr_i = 32'h1000_0014; bus.fifo_wdata_i = D1;
        tick();
        bus.fifo_wen_i = 1'b0; bus.fifo_awaddr_i = 32'hFFFF_FFFF; bus.fifo_wdata_i = '1;
        chk("fifo_req_busy", bus.busy_o, 1'b1);
        chk("fifo_req_wreq", bus.axi_wreq_o, 1'b1);
        serve(1, 2);
        check_idle("fifo_end");
        chk("fifo_accept_count", n_acc - acc0, 1);
        chk("fifo_bvalid_count", n_fbv - fbv0, 1);

        // Uncached store into lane 2
        ucd0 = n_ucd; acc0 = n_acc;
        push_exp(1'b1, 32'h1FE0_0008, 128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000,
                 16'h0300, 8'd0);
        bus.uc_wreq_i = 1'b1; bus.uc_awaddr_i = 32'h1FE0_0008;
        bus.uc_wdata_i = 32'hDEAD_BEEF; bus.uc_wstrb_i = 4'h3;
        tick();
        serve(0, 1);
        bus.uc_wreq_i = 1'b0;
        check_idle("uc_end");
        chk("uc_done_count", n_ucd - ucd0, 1);
        chk("uc_no_accept", n_acc - acc0, 0);

        // Uncached inputs change after grant; latched payload must hold
        push_exp(1'b1, 32'h8000_0004, 128'h0000_0000_0000_0000_1234_5678_0000_0000,
                 16'h00F0, 8'd0);
        bus.uc_wreq_i = 1'b1; bus.uc_awaddr_i = 32'h8000_0004;
        bus.uc_wdata_i = 32'h1234_5678; bus.uc_wstrb_i = 4'hF;
        tick();
        bus.uc_wdata_i = 32'hFFFF_FFFF; bus.uc_awaddr_i = 32'h0; bus.uc_wstrb_i = 4'h1;
        tick();
        chk("uc_hold_wdata", bus.axi_wdata_o, 128'h0000_0000_0000_0000_1234_5678_0000_0000);
        serve(1, 0);
        bus.uc_wreq_i = 1'b0;

        // bvalid during REQ is ignored
        fbv0 = n_fbv;
        push_exp(1'b0, 32'h3000_0000, D1, 16'hFFFF, 8'd3);
        bus.fifo_wen_i = 1'b1; bus.fifo_awaddr_i = 32'h3000_0000; bus.fifo_wdata_i = D1;
        tick();
        bus.fifo_wen_i = 1'b0;
        bus.axi_bvalid_i = 1'b1;
        tick();
        bus.axi_bvalid_i = 1'b0;
        chk("early_bvalid_stay_req", bus.axi_wreq_o, 1'b1);
        chk("early_bvalid_no_pulse", n_fbv - fbv0, 0);
        serve(0, 1);
        chk("early_bvalid_late_done", n_fbv - fbv0, 1);

        // Both requesting continuously from reset: uc, fifo, uc, fifo
        rst = 1'b0;
        bus.uc_wreq_i = 1'b1; bus.uc_awaddr_i = 32'h0000_000C;
        bus.uc_wdata_i = 32'hA5A5_0001; bus.uc_wstrb_i = 4'hF;
        bus.fifo_wen_i = 1'b1; bus.fifo_awaddr_i = 32'h2000_0047; bus.fifo_wdata_i = D2;
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b1, 32'h0000_000C, 128'hA5A5_0001_0000_0000_0000_0000_0000_0000,
                     16'hF000, 8'd0);
            push_exp(1'b0, 32'h2000_0040, D2, 16'hFFFF, 8'd3);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            serve(0, 0);
        end
        bus.uc_wreq_i = 1'b0; bus.fifo_wen_i = 1'b0;
        tick();
        check_idle("rr_end");

        // Reset during RESP drops the transaction
        ucd0 = n_ucd;
        push_exp(1'b1, 32'h4000_0000, 128'h0000_0000_0000_0000_0000_0000_1111_1111,
                 16'h0001, 8'd0);
        bus.uc_wreq_i = 1'b1; bus.uc_awaddr_i = 32'h4000_0000;
        bus.uc_wdata_i = 32'h1111_1111; bus.uc_wstrb_i = 4'h1;
        tick();
        bus.axi_wready_i = 1'b1;
        tick();
        bus.axi_wready_i = 1'b0;
        chk("resp_before_reset_busy", bus.busy_o, 1'b1);
        pend_q.delete();
        rst = 1'b0;
        bus.axi_bvalid_i = 1'b1;
        #1;
        check_idle("mid_rst");
        chk("mid_rst_payload", {bus.axi_awaddr_o, bus.axi_wstrb_o, bus.axi_len_o}, 56'h0);
        chk("mid_rst_wdata", bus.axi_wdata_o, 128'h0);
        chk("mid_rst_pulses", {bus.fifo_req_accept_o, bus.fifo_bvalid_o, bus.uc_done_o}, 3'b000);
        tick();
        chk("mid_rst_no_done", n_ucd - ucd0, 0);
        bus.axi_bvalid_i = 1'b0; bus.uc_wreq_i = 1'b0;
        push_exp(1'b0, 32'h5000_0010, D2, 16'hFFFF, 8'd3);
        bus.fifo_wen_i = 1'b1; bus.fifo_awaddr_i = 32'h5000_001F; bus.fifo_wdata_i = D2;
        rst = 1'b1;
        tick();
        bus.fifo_wen_i = 1'b0;
        chk("post_rst_grant", bus.axi_wreq_o, 1'b1);
        serve(0, 0);
        check_idle("post_rst_end");

        tick();
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("pend_queue_drained", pend_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
